fpga_tx_feeder: RTL
===================

Name: fpga_tx_feeder

Overview:
Byte-buffering scheduler directly upstream of fpga_transmitter. It accepts bytes from the local producer over a valid/ready interface and stores them in an internal FIFO. For each byte it drives sent_data/start into the transmitter, then sequences release and inter-frame gap from the transmitter's busy flag. This removes hand-timed start/data sequencing from every producer of the FPGA-to-FPGA link.

Parameters:
DEPTH, 8, FIFO depth in bytes; power of two, >= 2
GAP_CYCLES, 4, idle cycles with start low between consecutive frames; >= 1
TIMEOUT_CYCLES, 255, cycles to wait for busy rise before abort (optional feature only)

Ports:
clock  in  1  system clock, all logic on rising edge
reset  in  1  synchronous, active-high reset
in_data  in  8  byte from producer
in_valid  in  1  producer has a byte
in_ready  out  1  FIFO can accept; a transfer occurs when in_valid && in_ready at an edge
sent_data  out  8  byte presented to fpga_transmitter
start  out  1  request to fpga_transmitter
busy  in  1  fpga_transmitter busy flag
fifo_count  out  $clog2(DEPTH)+1  bytes currently buffered
frame_done  out  1  one-cycle pulse when a frame completes (busy falls)
timeout_err  out  1  sticky abort flag (optional feature; tied 0 otherwise)

Behaviour:
- One clock, synchronous active-high reset. Reset values: in_ready=1, sent_data=0, start=0, fifo_count=0, frame_done=0, timeout_err=0, FSM=IDLE, FIFO pointers=0.
- in_ready = (fifo_count < DEPTH), from registered count only; a full FIFO refuses a push even in a pop cycle.
- Simultaneous push and pop: count unchanged, both take effect. Pointers wrap modulo DEPTH.
- FSM:
  - IDLE: if fifo_count != 0, pop head into sent_data and go to ASSERT. Otherwise stay.
  - ASSERT: start=1, sent_data held stable. When busy=1, go to ACTIVE.
  - ACTIVE: start=1. When busy=0, pulse frame_done for one cycle, drop start next edge, and go to GAP.
  - GAP: start=0. Count GAP_CYCLES cycles, then go to IDLE.
- Latency: a byte accepted at edge N into an empty FIFO with the FSM in IDLE gives start=1 and valid sent_data from edge N+2.
- sent_data changes only on a pop in IDLE. It never changes while start=1.
- If busy=1 already in IDLE/GAP: no effect. ASSERT still waits for busy=1, which is immediate.
- Reset mid-frame: start drops at the reset edge and FIFO contents are discarded. The system resets the transmitter with the same reset.

Optional Feature:
FPGA_TX_FEEDER_TIMEOUT_EN
- Defined:
  - A counter runs in ASSERT.
  - If busy stays 0 for TIMEOUT_CYCLES cycles, timeout_err is set (sticky until reset), start drops, and the FSM goes to GAP.
  - The popped byte is dropped and frame_done is not pulsed.
- Undefined: ASSERT waits indefinitely; timeout_err is constant 0; no counter logic is present.

Decomposition:
- Package fpga_link_pkg:
  - BYTE_W=8
  - feeder state enum {IDLE, ASSERT, ACTIVE, GAP}
  - default GAP_CYCLES/TIMEOUT_CYCLES constants, shared with the transmitter/receiver benches
- One sub-module, fpga_sync_fifo (parameters WIDTH, DEPTH; push/pop/count/full/empty). Reusable later behind fpga_receiver.

Test Plan:
- Single byte 8'h01 pushed after reset; bench transmitter model raises busy 3 cycles after start and drops it 10 cycles later. Required:
  - start high at push+2, sent_data=8'h01
  - frame_done pulses once
  - start low for exactly GAP_CYCLES=4 cycles before IDLE
- Burst of 8 bytes (8'h01,02,04,...,80) with in_valid held:
  - in_ready deasserts when fifo_count=8
  - all 8 frames emitted in order, count returns to 0
  - sent_data never changes while start=1
- Push and pop in the same cycle at fifo_count=3 (ascending 8'h11,22,44,88 stream): count stays 3, and the byte order at sent_data is preserved across a pointer wrap.
- Full FIFO (count=8) with in_valid=1 during a pop cycle: push refused, and in_ready returns to 1 the cycle after the count drops to 7.
- Reset asserted while in ACTIVE with 5 bytes queued: next edge gives start=0, fifo_count=0, in_ready=1; byte 8'h55 pushed afterwards is transmitted normally.
- With FPGA_TX_FEEDER_TIMEOUT_EN, busy held 0, byte 8'hAA:
  - timeout_err=1 after 255 cycles of start
  - start drops, no frame_done
  - next byte 8'hFF still sent once busy responds

Source files
------------

// File: rtl/fpga_link_pkg.sv
// -----------------------------------------------------------------------------
// fpga_link_pkg
// Shared types and constants for the FPGA-to-FPGA link blocks (feeder,
// transmitter, receiver) and their benches.
//   BYTE_W                 - width of one link byte
//   feeder_state_t         - fpga_tx_feeder scheduler states
//   DEFAULT_GAP_CYCLES     - idle cycles with start low between frames
//   DEFAULT_TIMEOUT_CYCLES - cycles to wait for busy before aborting a frame
// -----------------------------------------------------------------------------
package fpga_link_pkg;

    localparam int BYTE_W                 = 8;
    localparam int DEFAULT_GAP_CYCLES     = 4;
    localparam int DEFAULT_TIMEOUT_CYCLES = 255;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ASSERT = 2'd1,
        ACTIVE = 2'd2,
        GAP    = 2'd3
    } feeder_state_t;

endpackage

// File: rtl/fpga_sync_fifo.sv
// -----------------------------------------------------------------------------
// fpga_sync_fifo
// Single-clock FIFO with registered occupancy count. Pointers wrap modulo
// DEPTH (DEPTH must be a power of two). A push while full and a pop while
// empty are ignored. Push and pop in the same cycle both take effect.
// Ports:
//   clock, reset      - rising-edge clock, synchronous active-high reset
//   push, push_data   - write request and data
//   pop, pop_data     - read request; pop_data shows the head combinationally
//   count             - entries currently stored (0..DEPTH)
//   full, empty       - decoded from the registered count
// -----------------------------------------------------------------------------
module fpga_sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   push,
    input  logic [WIDTH-1:0]       push_data,
    input  logic                   pop,
    output logic [WIDTH-1:0]       pop_data,
    output logic [$clog2(DEPTH):0] count,
    output logic                   full,
    output logic                   empty
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full     = (count == CW'(DEPTH));
    assign empty    = (count == '0);
    assign do_push  = push && !full;
    assign do_pop   = pop && !empty;
    assign pop_data = mem[rd_ptr];

    // Storage carries no reset; stale entries are never visible because the
    // count gates every read.
    always_ff @(posedge clock) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/fpga_tx_feeder.sv
// -----------------------------------------------------------------------------
// fpga_tx_feeder
// Buffers producer bytes and schedules them one frame at a time into
// fpga_transmitter: loads sent_data, holds start until the transmitter has
// raised and dropped busy, then keeps start low for GAP_CYCLES cycles.
// Optional feature macro: FPGA_TX_FEEDER_TIMEOUT_EN -- aborts a frame whose
// busy never rises within TIMEOUT_CYCLES cycles of start and sets the sticky
// timeout_err flag. Without the macro timeout_err is tied 0.
// Ports:
//   clock, reset         - rising-edge clock, synchronous active-high reset
//   in_data/in_valid/in_ready - producer interface
//   sent_data, start     - request to the transmitter
//   busy                 - transmitter busy flag
//   fifo_count           - bytes currently buffered
//   frame_done           - one-cycle pulse when a frame completes
//   timeout_err          - sticky abort flag (optional feature)
//   state                - scheduler state, for observation
// Handshake: a byte transfers on a rising edge where in_valid && in_ready.
// in_ready depends only on the registered count, so a full FIFO refuses a
// push even in the cycle that pops it.
// -----------------------------------------------------------------------------
module fpga_tx_feeder
    import fpga_link_pkg::*;
#(
    parameter int DEPTH          = 8,
    parameter int GAP_CYCLES     = DEFAULT_GAP_CYCLES,
    parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic [BYTE_W-1:0]      in_data,
    input  logic                   in_valid,
    output logic                   in_ready,
    output logic [BYTE_W-1:0]      sent_data,
    output logic                   start,
    input  logic                   busy,
    output logic [$clog2(DEPTH):0] fifo_count,
    output logic                   frame_done,
    output logic                   timeout_err,
    output feeder_state_t          state
);
    localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam logic [GW-1:0] GAP_LAST = GW'(GAP_CYCLES - 1);

    if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_bad_depth
        $error("fpga_tx_feeder: DEPTH must be a power of two >= 2");
    end
    if (GAP_CYCLES < 1) begin : g_bad_gap
        $error("fpga_tx_feeder: GAP_CYCLES must be >= 1");
    end
    if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
        $error("fpga_tx_feeder: TIMEOUT_CYCLES must be >= 1");
    end

    logic              fifo_full;
    logic              fifo_empty;
    logic              pop;
    logic [BYTE_W-1:0] head;
    logic [GW-1:0]     gap_cnt;

    // Popping only in IDLE guarantees sent_data never moves while start=1.
    assign pop      = (state == IDLE) && !fifo_empty;
    assign in_ready = !fifo_full;

    fpga_sync_fifo #(
        .WIDTH (BYTE_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clock     (clock),
        .reset     (reset),
        .push      (in_valid),
        .push_data (in_data),
        .pop       (pop),
        .pop_data  (head),
        .count     (fifo_count),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

`ifdef FPGA_TX_FEEDER_TIMEOUT_EN
    localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CYCLES - 1);
    logic [TW-1:0] to_cnt;
`else
    assign timeout_err = 1'b0;
`endif

    always_ff @(posedge clock) begin
        if (reset) begin
            state      <= IDLE;
            sent_data  <= '0;
            start      <= 1'b0;
            frame_done <= 1'b0;
            gap_cnt    <= '0;
`ifdef FPGA_TX_FEEDER_TIMEOUT_EN
            to_cnt      <= '0;
            timeout_err <= 1'b0;
`endif
        end else begin
            frame_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (pop) begin
                        sent_data <= head;
                        state     <= ASSERT;
`ifdef FPGA_TX_FEEDER_TIMEOUT_EN
                        to_cnt    <= '0;
`endif
                    end
                end
                ASSERT: begin
                    start <= 1'b1;
                    if (busy) begin
                        state <= ACTIVE;
                    end
`ifdef FPGA_TX_FEEDER_TIMEOUT_EN
                    // Only cycles in which start was already visible to the
                    // transmitter count toward the timeout.
                    else if (start) begin
                        if (to_cnt == TO_LAST) begin
                            timeout_err <= 1'b1;
                            start       <= 1'b0;
                            gap_cnt     <= '0;
                            state       <= GAP;
                        end else begin
                            to_cnt <= to_cnt + 1'b1;
                        end
                    end
`endif
                end
                ACTIVE: begin
                    start <= 1'b1;
                    if (!busy) begin
                        frame_done <= 1'b1;
                        start      <= 1'b0;
                        gap_cnt    <= '0;
                        state      <= GAP;
                    end
                end
                GAP: begin
                    start <= 1'b0;
                    if (gap_cnt == GAP_LAST) begin
                        state <= IDLE;
                    end else begin
                        gap_cnt <= gap_cnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
